// File: rtl/robo_pkg.sv
// robo_pkg: shared state encodings for the robot controller.
//   STATE_W        - width of the state register / estado_o debug port
//   state_t        - INICIO..PARADO, codes 0..5 (6 and 7 are illegal)
//   RECOVER_STATE  - where an illegal state code lands on the next edge
package robo_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        INICIO     = 3'd0,
        PROCURAR   = 3'd1,
        ROTACIONAR = 3'd2,
        SEGUIR     = 3'd3,
        REMOVER    = 3'd4,
        PARADO     = 3'd5
    } state_t;

    localparam state_t RECOVER_STATE = INICIO;

endpackage

// File: rtl/robo_debounce.sv
// robo_debounce: single-bit level filter.
//   clock - rising-edge clock
//   reset - synchronous, active-high; clears filter output and counter
//   din   - raw sensor level
//   dout  - filtered level; follows din only after din has differed from
//           dout on DEB_CYCLES consecutive edges
module robo_debounce #(
    parameter int DEB_CYCLES = 2,
    parameter int CNT_W      = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            dout <= 1'b0;
            cnt  <= '0;
        end else if (din != dout) begin
            // Disagreement streak: commit on its DEB_CYCLES-th edge.
            if (cnt == LAST) begin
                dout <= din;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            // Any agreeing sample breaks the streak, so short pulses vanish.
            cnt <= '0;
        end
    end

endmodule

// File: rtl/robo_ctrl_param.sv
// robo_ctrl_param: wall-following robot controller (Moore FSM).
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   H, L, U, B        - raw sensors: obstacle, left wall, debris, pause
//   Front/Turn/Remove - actuator commands decoded from the state register
//   stuck             - high only in PARADO
//   paused            - filtered B is freezing the FSM
//   estado_o          - current state code (debug)
module robo_ctrl_param
    import robo_pkg::*;
#(
    parameter int DEB_CYCLES    = 2,
    parameter int SEARCH_LIMIT  = 16,
    parameter int MAX_TURNS     = 4,
    parameter int REMOVE_CYCLES = 3,
    parameter int CNT_W         = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               H,
    input  logic               L,
    input  logic               U,
    input  logic               B,
    output logic               Front,
    output logic               Turn,
    output logic               Remove,
    output logic               stuck,
    output logic               paused,
    output logic [STATE_W-1:0] estado_o
);

    localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_LIMIT - 1);
    localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(MAX_TURNS - 1);
    localparam logic [CNT_W-1:0] REM_LAST    = CNT_W'(REMOVE_CYCLES - 1);

    logic h_f, l_f, u_f, b_f;

    robo_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_h (
        .clock(clock), .reset(reset), .din(H), .dout(h_f));
    robo_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_l (
        .clock(clock), .reset(reset), .din(L), .dout(l_f));
    robo_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_u (
        .clock(clock), .reset(reset), .din(U), .dout(u_f));
    robo_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_b (
        .clock(clock), .reset(reset), .din(B), .dout(b_f));

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    logic [CNT_W-1:0] search_q, search_d;
    logic [CNT_W-1:0] turn_q, turn_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             legal;
    logic             hold;

    // Illegal codes are never frozen by pause so they always recover.
    assign legal = (state_q <= PARADO);
    assign hold  = b_f && legal && (state_q != PARADO);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= INICIO;
            ret_q    <= PROCURAR;
            search_q <= '0;
            turn_q   <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            search_q <= search_d;
            turn_q   <= turn_d;
            rem_q    <= rem_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        search_d = search_q;
        turn_d   = turn_q;
        rem_d    = rem_q;
        if (!hold) begin
            case (state_q)
                INICIO: state_d = PROCURAR;
                PROCURAR: begin
                    search_d = '0;
                    if (u_f) begin
                        ret_d   = PROCURAR;
                        state_d = REMOVER;
                    end else if (h_f) begin
                        state_d = ROTACIONAR;
                    end else if (l_f) begin
                        state_d = SEGUIR;
                    end else if (search_q == SEARCH_LAST) begin
                        state_d = ROTACIONAR;
                    end else begin
                        search_d = search_q + 1'b1;
                    end
                end
                ROTACIONAR: begin
                    turn_d = '0;
                    if (u_f) begin
                        ret_d   = PROCURAR;
                        state_d = REMOVER;
                    end else if (!h_f) begin
                        state_d = l_f ? SEGUIR : PROCURAR;
                    end else if (turn_q == TURN_LAST) begin
                        state_d = PARADO;
                        turn_d  = turn_q;
                    end else begin
                        turn_d = turn_q + 1'b1;
                    end
                end
                SEGUIR: begin
                    if (u_f) begin
                        ret_d   = SEGUIR;
                        state_d = REMOVER;
                    end else if (h_f) begin
                        state_d = ROTACIONAR;
                    end else if (!l_f) begin
                        state_d = PROCURAR;
                    end
                end
                REMOVER: begin
                    // H and L are deliberately ignored here.
                    if (rem_q == REM_LAST) begin
                        rem_d = '0;
                        if (!u_f) begin
                            state_d = ret_q;
                        end
                    end else begin
                        rem_d = rem_q + 1'b1;
                    end
                end
                PARADO: state_d = PARADO;
                default: begin
                    state_d  = RECOVER_STATE;
                    ret_d    = PROCURAR;
                    search_d = '0;
                    turn_d   = '0;
                    rem_d    = '0;
                end
            endcase
        end
    end

    always_comb begin
        Front  = 1'b0;
        Turn   = 1'b0;
        Remove = 1'b0;
        stuck  = 1'b0;
        case (state_q)
            PROCURAR, SEGUIR: Front  = 1'b1;
            ROTACIONAR:       Turn   = 1'b1;
            REMOVER:          Remove = 1'b1;
            PARADO:           stuck  = 1'b1;
            default:          ;
        endcase
        if (hold) begin
            Front  = 1'b0;
            Turn   = 1'b0;
            Remove = 1'b0;
        end
    end

    assign paused   = hold;
    assign estado_o = state_q;

endmodule

// File: tb/tb_robo_ctrl_param.sv
module tb_robo_ctrl_param;

    logic       clock;
    logic       reset;
    logic       H, L, U, B;
    logic       Front, Turn, Remove, stuck, paused;
    logic [2:0] estado_o;
    logic [7:0] outs_w;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    localparam logic [7:0] O_NONE  = 8'h00;
    localparam logic [7:0] O_FRONT = 8'h01;
    localparam logic [7:0] O_TURN  = 8'h02;
    localparam logic [7:0] O_REM   = 8'h04;
    localparam logic [7:0] O_PAUSE = 8'h08;
    localparam logic [7:0] O_STUCK = 8'h10;

    robo_ctrl_param dut (
        .clock(clock), .reset(reset),
        .H(H), .L(L), .U(U), .B(B),
        .Front(Front), .Turn(Turn), .Remove(Remove),
        .stuck(stuck), .paused(paused), .estado_o(estado_o)
    );

    assign outs_w = {3'b000, stuck, paused, Remove, Turn, Front};

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // driver: advance n rising edges, then settle 1 time unit
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [7:0] e;
        int i;

        reset = 1'b1; H = 0; L = 0; U = 0; B = 0;
        step(3);
        check("rst_state", 8'(estado_o), 8'd0);
        check("rst_outs", outs_w, O_NONE);
        reset = 1'b0;
        check("first_cycle_outs", outs_w, O_NONE);
        step(1);
        check("start_state", 8'(estado_o), 8'd1);
        check("start_outs", outs_w, O_FRONT);
        step(15);
        check("search_hold", 8'(estado_o), 8'd1);
        step(1);
        check("timeout_rot", 8'(estado_o), 8'd2);
        check("timeout_outs", outs_w, O_TURN);
        step(1);
        check("timeout_exit", 8'(estado_o), 8'd1);

        // wall follow and turn
        L = 1;
        step(2);
        check("l_deb_wait", 8'(estado_o), 8'd1);
        step(1);
        check("l_seguir", 8'(estado_o), 8'd3);
        check("seguir_outs", outs_w, O_FRONT);
        H = 1;
        step(2);
        check("h_deb_wait", 8'(estado_o), 8'd3);
        step(1);
        check("h_rot", 8'(estado_o), 8'd2);
        H = 0;
        step(2);
        check("h_drop_wait", 8'(estado_o), 8'd2);
        step(1);
        check("h_drop_seguir", 8'(estado_o), 8'd3);
        L = 0;
        step(3);
        check("l_drop_procurar", 8'(estado_o), 8'd1);
        L = 1;
        step(3);
        check("l_again_seguir", 8'(estado_o), 8'd3);

        // one-cycle debris glitch is filtered out
        U = 1;
        step(1);
        U = 0;
        step(3);
        check("glitch_state", 8'(estado_o), 8'd3);
        check("glitch_outs", outs_w, O_FRONT);

        // removal: U high for 4 raw cycles gives two full attempts
        exp_q = {8'd3, 8'd3, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd3, 8'd3};
        U = 1;
        i = 0;
        while (exp_q.size() > 0) begin
            step(1);
            i++;
            if (i == 4) U = 0;
            e = exp_q.pop_front();
            check($sformatf("rem_seq_state_%0d", i), 8'(estado_o), e);
            check($sformatf("rem_seq_remove_%0d", i), 8'(Remove), (e == 8'd4) ? 8'd1 : 8'd0);
        end

        // pause in the middle of a removal
        U = 1;
        step(2);
        U = 0;
        step(1);
        check("pause_rem_entry", 8'(estado_o), 8'd4);
        B = 1;
        step(1);
        check("pause_pre_outs", outs_w, O_REM);
        step(1);
        check("pause_state", 8'(estado_o), 8'd4);
        check("pause_outs", outs_w, O_PAUSE);
        for (int k = 0; k < 3; k++) begin
            step(1);
            check($sformatf("pause_hold_%0d", k), outs_w, O_PAUSE);
        end
        B = 0;
        step(1);
        check("pause_release_wait", outs_w, O_PAUSE);
        step(1);
        check("resume_rem", outs_w, O_REM);
        step(1);
        check("resume_return", 8'(estado_o), 8'd3);
        check("resume_outs", outs_w, O_FRONT);

        // stuck: H held forever while following the wall
        H = 1;
        step(2);
        check("stuck_wait", 8'(estado_o), 8'd3);
        for (int k = 0; k < 4; k++) begin
            step(1);
            check($sformatf("stuck_rot_%0d", k), 8'(estado_o), 8'd2);
        end
        step(1);
        check("parado_state", 8'(estado_o), 8'd5);
        check("parado_outs", outs_w, O_STUCK);
        B = 1;
        step(3);
        check("parado_b_state", 8'(estado_o), 8'd5);
        check("parado_b_outs", outs_w, O_STUCK);
        H = 0; L = 0; B = 0;
        step(4);
        check("parado_absorb", 8'(estado_o), 8'd5);

        // reset leaves PARADO
        reset = 1;
        step(1);
        check("rst_parado", 8'(estado_o), 8'd0);
        reset = 0;
        step(1);
        check("rst_parado_restart", 8'(estado_o), 8'd1);

        // reset in the middle of a removal entered from SEGUIR
        L = 1;
        step(3);
        check("mid_seguir", 8'(estado_o), 8'd3);
        U = 1;
        step(3);
        check("mid_rem", 8'(estado_o), 8'd4);
        check("mid_ret_seguir", 8'(dut.ret_q), 8'd3);
        reset = 1; U = 0; L = 0;
        step(1);
        check("mid_rst_state", 8'(estado_o), 8'd0);
        check("mid_rst_outs", outs_w, O_NONE);
        check("mid_rst_ret", 8'(dut.ret_q), 8'd1);
        reset = 0;
        step(1);
        check("mid_restart", 8'(estado_o), 8'd1);
        U = 1;
        step(2);
        U = 0;
        step(1);
        check("ret_rem_entry", 8'(estado_o), 8'd4);
        step(2);
        check("ret_rem_last", 8'(estado_o), 8'd4);
        step(1);
        check("ret_procurar", 8'(estado_o), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
